sprite_overlay: RTL and testbench

Pixel-pipeline compositor that drives the (x, y) lookup side of a 1-bit sprite image module and merges the returned RGBA over the background pixel stream. It sits between the VGA timing/background path and the output DAC registers. It is used for full-screen banners such as the game-over and start sprites. It handles sprite placement, clipping, per-frame position latching and optional frame-counted blinking.

---
 rtl/sprite_overlay_pkg.sv | 21 ++
 rtl/sprite_overlay_blink_fsm.sv | 49 ++++
 rtl/sprite_overlay.sv | 133 +++++++++++++
 tb/tb_sprite_overlay.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_overlay_pkg.sv
// Shared display constants, colour bundle and blink-state encoding
// for the sprite overlay compositor.
package sprite_overlay_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;
  localparam int COLOR_W  = 8;

  typedef enum logic {
    VISIBLE = 1'b0,
    HIDDEN  = 1'b1
  } blink_state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/sprite_overlay_blink_fsm.sv
// Frame-counted blink phase: toggles VISIBLE/HIDDEN every
// BLINK_FRAMES frame_start pulses while blink_en is high.
module sprite_blink_fsm
  import sprite_overlay_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic blink_en,
  output logic visible_phase
);

  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [FW-1:0] LAST = FW'(BLINK_FRAMES - 1);

  blink_state_t state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VISIBLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (!blink_en) begin
      state_d = VISIBLE;
      fcnt_d  = '0;
    end else if (frame_start) begin
      if (fcnt_q == LAST) begin
        fcnt_d  = '0;
        state_d = (state_q == VISIBLE) ? HIDDEN : VISIBLE;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign visible_phase = (state_q == VISIBLE);

endmodule

// File: rtl/sprite_overlay.sv
// Two-stage sprite compositor: hit test and image lookup in stage 1,
// alpha merge over background in stage 2.
module sprite_overlay
  import sprite_overlay_pkg::*;
#(
  parameter int SPR_W        = 256,
  parameter int SPR_H        = 32,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               de_in,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [COLOR_W-1:0] bg_r,
  input  logic [COLOR_W-1:0] bg_g,
  input  logic [COLOR_W-1:0] bg_b,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               show,
  input  logic               blink_en,
  output logic [COORD_W-1:0] img_x,
  output logic [COORD_W-1:0] img_y,
  input  logic [COLOR_W-1:0] img_r,
  input  logic [COLOR_W-1:0] img_g,
  input  logic [COLOR_W-1:0] img_b,
  input  logic               img_a,
  output logic [COLOR_W-1:0] out_r,
  output logic [COLOR_W-1:0] out_g,
  output logic [COLOR_W-1:0] out_b,
  output logic               de_out,
  output logic               hs_out,
  output logic               vs_out
);

  logic [COORD_W-1:0] lx, ly;
  logic               show_l;
  logic               visible_phase;

  sprite_blink_fsm #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .blink_en     (blink_en),
    .visible_phase(visible_phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lx     <= '0;
      ly     <= '0;
      show_l <= 1'b0;
    end else if (frame_start) begin
      lx     <= pos_x;
      ly     <= pos_y;
      show_l <= show;
    end
  end

  // One extra bit keeps pix - l from wrapping back into range.
  logic [COORD_W:0] dx, dy;
  logic             on_screen, hit;

  assign dx = {1'b0, pix_x} - {1'b0, lx};
  assign dy = {1'b0, pix_y} - {1'b0, ly};

  assign on_screen = (pix_x < COORD_W'(H_ACTIVE))
                   & (pix_y < COORD_W'(V_ACTIVE));

  assign hit = de_in & on_screen
             & (pix_x >= lx) & (dx < (COORD_W+1)'(SPR_W))
             & (pix_y >= ly) & (dy < (COORD_W+1)'(SPR_H));

  logic hit1, vis1, de1, hs1, vs1;
  rgb_t bg1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_x <= '0;
      img_y <= '0;
      hit1  <= 1'b0;
      vis1  <= 1'b0;
      bg1   <= '0;
      de1   <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
    end else begin
      img_x <= hit ? dx[COORD_W-1:0] : '0;
      img_y <= hit ? dy[COORD_W-1:0] : '0;
      hit1  <= hit;
      vis1  <= show_l & visible_phase;
      bg1   <= '{r: bg_r, g: bg_g, b: bg_b};
      de1   <= de_in;
      hs1   <= hs_in;
      vs1   <= vs_in;
    end
  end

  rgb_t pix_d;

  always_comb begin
    pix_d = bg1;
    unique case (1'b1)
      !de1:                  pix_d = '0;
      hit1 & vis1 & img_a:   pix_d = '{r: img_r, g: img_g, b: img_b};
      default:               pix_d = bg1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r  <= '0;
      out_g  <= '0;
      out_b  <= '0;
      de_out <= 1'b0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
    end else begin
      out_r  <= pix_d.r;
      out_g  <= pix_d.g;
      out_b  <= pix_d.b;
      de_out <= de1;
      hs_out <= hs1;
      vs_out <= vs1;
    end
  end

endmodule

// File: tb/tb_sprite_overlay.sv
// Directed bench for sprite_overlay: placement, alpha, clipping,
// position latch, blinking and reset behaviour.
module tb_sprite_overlay;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic [9:0] pix_x, pix_y;
  logic       de_in, hs_in, vs_in;
  logic [7:0] bg_r, bg_g, bg_b;
  logic [9:0] pos_x, pos_y;
  logic       show, blink_en;
  logic [9:0] img_x, img_y;
  logic [7:0] img_r, img_g, img_b;
  logic       img_a;
  logic [7:0] out_r, out_g, out_b;
  logic       de_out, hs_out, vs_out;

  int tests = 0;
  int fails = 0;
  int mode  = 0;

  localparam logic [23:0] BG  = 24'h102030;
  localparam logic [23:0] RED = 24'hff0000;
  localparam logic [23:0] GRN = 24'h00ff00;

  always #5 clk = ~clk;

  sprite_overlay #(
    .SPR_W(256), .SPR_H(32), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pix_x(pix_x), .pix_y(pix_y),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .pos_x(pos_x), .pos_y(pos_y), .show(show), .blink_en(blink_en),
    .img_x(img_x), .img_y(img_y),
    .img_r(img_r), .img_g(img_g), .img_b(img_b), .img_a(img_a),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  // Image ROM model: mode 0 opaque red, mode 1 green with a hole at (10,5)
  always_comb begin
    {img_r, img_g, img_b} = RED;
    img_a = 1'b1;
    if (mode == 1) begin
      {img_r, img_g, img_b} = GRN;
      img_a = !(img_x == 10'd10 && img_y == 10'd5);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fs_pulse();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [9:0] x, input logic [9:0] y,
                      input bit fs, input logic [23:0] exp,
                      input logic [9:0] ex, input logic [9:0] ey,
                      input string nm);
    @(negedge clk);
    pix_x = x; pix_y = y; de_in = 1'b1;
    hs_in = x[0]; vs_in = y[0]; frame_start = fs;
    @(negedge clk);
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0; frame_start = 1'b0;
    chk({nm, " img_x"}, 32'(img_x), 32'(ex));
    chk({nm, " img_y"}, 32'(img_y), 32'(ey));
    chk({nm, " de_out early"}, 32'(de_out), 32'd0);
    @(negedge clk);
    chk({nm, " rgb"}, 32'({out_r, out_g, out_b}), 32'(exp));
    chk({nm, " syncs"}, 32'({de_out, hs_out, vs_out}),
        32'({1'b1, x[0], y[0]}));
  endtask

  task automatic set_pos(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    pos_x = x; pos_y = y; show = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    chk("reset rgb", 32'({out_r, out_g, out_b}), 32'd0);
    chk("reset syncs", 32'({de_out, hs_out, vs_out}), 32'd0);
    chk("reset img", 32'({img_x, img_y}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(10'd0, 10'd0, 1'b0, BG, 10'd0, 10'd0, "reset no show");
  endtask

  task automatic test_placement();
    mode = 0;
    set_pos(10'd192, 10'd224);
    fs_pulse();
    send(10'd191, 10'd224, 1'b0, BG,  10'd0,   10'd0,  "pl left");
    send(10'd448, 10'd224, 1'b0, BG,  10'd0,   10'd0,  "pl right");
    send(10'd192, 10'd224, 1'b0, RED, 10'd0,   10'd0,  "pl tl");
    send(10'd447, 10'd255, 1'b0, RED, 10'd255, 10'd31, "pl br");
    send(10'd300, 10'd256, 1'b0, BG,  10'd0,   10'd0,  "pl below");
  endtask

  task automatic test_transparency();
    mode = 1;
    set_pos(10'd0, 10'd0);
    fs_pulse();
    send(10'd10, 10'd5, 1'b0, BG,  10'd10, 10'd5, "tr hole");
    send(10'd9,  10'd5, 1'b0, GRN, 10'd9,  10'd5, "tr left");
    send(10'd11, 10'd5, 1'b0, GRN, 10'd11, 10'd5, "tr right");
    send(10'd10, 10'd4, 1'b0, GRN, 10'd10, 10'd4, "tr up");
    @(negedge clk);
    chk("tr latency tail", 32'(de_out), 32'd0);
    mode = 0;
  endtask

  task automatic test_clipping();
    set_pos(10'd600, 10'd470);
    fs_pulse();
    send(10'd639, 10'd479, 1'b0, RED, 10'd39, 10'd9, "cl corner");
    send(10'd600, 10'd470, 1'b0, RED, 10'd0,  10'd0, "cl origin");
    send(10'd0,   10'd0,   1'b0, BG,  10'd0,  10'd0, "cl wrap00");
    send(10'd39,  10'd9,   1'b0, BG,  10'd0,  10'd0, "cl wrap39");
    send(10'd599, 10'd470, 1'b0, BG,  10'd0,  10'd0, "cl left");
  endtask

  task automatic test_pos_latch();
    set_pos(10'd0, 10'd0);
    fs_pulse();
    send(10'd0, 10'd0, 1'b0, RED, 10'd0, 10'd0, "pos old");
    set_pos(10'd100, 10'd100);
    send(10'd0,   10'd0,   1'b0, RED, 10'd0, 10'd0, "pos mid old");
    send(10'd100, 10'd100, 1'b0, BG,  10'd0, 10'd0, "pos mid new");
    fs_pulse();
    send(10'd0,   10'd0,   1'b0, BG,  10'd0, 10'd0, "pos moved old");
    send(10'd100, 10'd100, 1'b0, RED, 10'd0, 10'd0, "pos moved new");
    set_pos(10'd0, 10'd0);
    send(10'd0, 10'd0, 1'b1, BG,  10'd0, 10'd0, "pos fs coincide");
    send(10'd0, 10'd0, 1'b0, RED, 10'd0, 10'd0, "pos fs after");
  endtask

  task automatic test_blink();
    set_pos(10'd0, 10'd0);
    blink_en = 1'b0;
    fs_pulse();
    send(10'd1, 10'd1, 1'b0, RED, 10'd1, 10'd1, "bl f0 vis");
    @(negedge clk);
    blink_en = 1'b1;
    fs_pulse();
    send(10'd1, 10'd1, 1'b0, RED, 10'd1, 10'd1, "bl f1 vis");
    fs_pulse();
    send(10'd1, 10'd1, 1'b0, BG,  10'd1, 10'd1, "bl f2 hid");
    fs_pulse();
    send(10'd1, 10'd1, 1'b0, BG,  10'd1, 10'd1, "bl f3 hid");
    fs_pulse();
    send(10'd1, 10'd1, 1'b0, RED, 10'd1, 10'd1, "bl f4 vis");
    fs_pulse();
    fs_pulse();
    send(10'd1, 10'd1, 1'b0, BG,  10'd1, 10'd1, "bl f6 hid");
    @(negedge clk);
    blink_en = 1'b0;
    send(10'd1, 10'd1, 1'b0, RED, 10'd1, 10'd1, "bl drop");
  endtask

  task automatic test_reset_mid();
    set_pos(10'd0, 10'd0);
    fs_pulse();
    @(negedge clk);
    pix_x = 10'd3; pix_y = 10'd2; de_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("rm before rgb", 32'({out_r, out_g, out_b}), 32'(RED));
    chk("rm before img", 32'({img_x, img_y}), 32'({10'd3, 10'd2}));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rm rgb", 32'({out_r, out_g, out_b}), 32'd0);
    chk("rm syncs", 32'({de_out, hs_out, vs_out}), 32'd0);
    chk("rm img", 32'({img_x, img_y}), 32'd0);
    @(negedge clk);
    de_in = 1'b0;
    rst_n = 1'b1;
    send(10'd3, 10'd2, 1'b0, BG,  10'd3, 10'd2, "rm after bg");
    fs_pulse();
    send(10'd3, 10'd2, 1'b0, RED, 10'd3, 10'd2, "rm after fs");
  endtask

  initial begin
    frame_start = 1'b0;
    pix_x = '0; pix_y = '0;
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    {bg_r, bg_g, bg_b} = BG;
    pos_x = '0; pos_y = '0;
    show = 1'b0; blink_en = 1'b0;
    test_reset();
    test_placement();
    test_transparency();
    test_clipping();
    test_pos_latch();
    test_blink();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
